dec_pipe: RTL and testbench

- Parametrised, pipelined binary decoder: the registered successor of the combinational 8-to-256 decoder.
- Converts an IN_W-bit code into a 2**IN_W-bit word using one of three selectable modes: one-hot, thermometer, inverted one-hot.
- Two-stage elastic pipeline with valid/ready handshakes on both sides, plus a saturating transaction counter.
- Sits between a code producer and wide-vector consumers in the approximate-logic benchmark datapaths.

---
 rtl/dec_pkg.sv | 11 +
 rtl/dec_core.sv | 40 ++++
 rtl/dec_pipe.sv | 90 +++++++++
 tb/tb_dec_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared constants for the pipelined decoder: mode encodings and mode field width.
package dec_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ONEHOT = 2'd0;
  localparam logic [MODE_W-1:0] MODE_THERM  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_INV    = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/dec_core.sv
// Combinational code-to-word decoder: one-hot, thermometer or inverted one-hot.
// The reserved mode yields an all-zero word with err raised.
module dec_core
  import dec_pkg::*;
#(
  parameter int unsigned IN_W = 8
) (
  input  logic [IN_W-1:0]        code,
  input  logic [MODE_W-1:0]      mode,
  output logic [(2**IN_W)-1:0]   word,
  output logic                   err
);

  localparam int unsigned OUT_W = 2**IN_W;

  logic [OUT_W-1:0] ones;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] therm;

  // Build the three candidate words by shifting; the thermometer shifts the
  // all-ones mask one extra place so code = OUT_W-1 clears the mask to zero.
  always_comb begin
    ones   = '1;
    onehot = OUT_W'(1) << code;
    therm  = ~((ones << code) << 1);
  end

  // Select the word for the requested mode.
  always_comb begin
    word = '0;
    err  = 1'b0;
    case (mode)
      MODE_ONEHOT: word = onehot;
      MODE_THERM:  word = therm;
      MODE_INV:    word = ~onehot;
      default:     err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/dec_pipe.sv
// Two-stage elastic pipeline around dec_core with valid/ready on both sides
// and a saturating count of completed output handshakes.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [MODE_W-1:0]     in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**IN_W)-1:0]  out_data,
  output logic                  out_err,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int unsigned OUT_W = 2**IN_W;

  logic                  va;
  logic [IN_W-1:0]       a_code;
  logic [MODE_W-1:0]     a_mode;
  logic                  vb;
  logic                  ready_a;
  logic                  ready_b;
  logic [OUT_W-1:0]      dec_word;
  logic                  dec_err;

  // Each stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    ready_b  = !vb || out_ready;
    ready_a  = !va || ready_b;
    in_ready = ready_a;
  end

  // Stage A: capture code and mode together at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va     <= 1'b0;
      a_code <= '0;
      a_mode <= '0;
    end else if (ready_a) begin
      va <= in_valid;
      if (in_valid) begin
        a_code <= in_data;
        a_mode <= in_mode;
      end
    end
  end

  dec_core #(
    .IN_W (IN_W)
  ) u_core (
    .code (a_code),
    .mode (a_mode),
    .word (dec_word),
    .err  (dec_err)
  );

  // Stage B: register the decoded beat; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (ready_b) begin
      out_valid <= va;
      if (va) begin
        out_data <= dec_word;
        out_err  <= dec_err;
      end
    end
  end

  assign vb = out_valid;

  // Count output handshakes, sticking at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (out_valid && out_ready && (txn_count != '1)) begin
      txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dec_pipe.sv
// Scoreboard bench for dec_pipe: a driver pushes expected beats from a
// reference decoder model, a monitor pops and compares on each handshake.
module tb_dec_pipe;

  typedef struct packed {
    logic [255:0] d;
    logic         e;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         out_err;
  logic [15:0]  txn_count;

  logic         in_ready_s;
  logic         out_valid_s;
  logic [255:0] out_data_s;
  logic         out_err_s;
  logic [3:0]   txn_count_s;

  beat_t        exp_q[$];
  int unsigned  exp_cnt = 0;
  int unsigned  n_vec   = 0;
  int unsigned  n_chk   = 0;
  int unsigned  n_fail  = 0;
  int unsigned  bp_mode = 0;

  always #5 clk = ~clk;

  dec_pipe #(.IN_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .txn_count (txn_count)
  );

  dec_pipe #(.IN_W(8), .CNT_W(4)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
    .out_err   (out_err_s),
    .txn_count (txn_count_s)
  );

  // Reference decoder, bit by bit from the mode rules.
  function automatic beat_t model(input int unsigned k, input int unsigned m);
    beat_t b;
    b.e = (m == 3);
    for (int i = 0; i < 256; i++) begin
      case (m)
        0:       b.d[i] = (i == k);
        1:       b.d[i] = (i <= k);
        2:       b.d[i] = (i != k);
        default: b.d[i] = 1'b0;
      endcase
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Consumer backpressure: 0 always ready, 1 stalled, 2 random.
  initial out_ready = 1'b1;
  always @(negedge clk) begin
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: counter, hold-under-stall and scoreboard checks.
  bit    prev_stall = 1'b0;
  beat_t prev_b;
  always @(negedge clk) begin
    beat_t e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("txn_count", 257'(txn_count), 257'(exp_cnt));
      chk("txn_count_sat", 257'(txn_count_s), 257'((exp_cnt > 15) ? 15 : exp_cnt));
      if (prev_stall) begin
        chk("hold_valid", 257'(out_valid), 257'(1));
        chk("hold_beat", {out_data, out_err}, prev_b);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 257'(1), 257'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", {out_data, out_err}, e);
        end
        exp_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_b     = {out_data, out_err};
    end
  end

  // Present a beat (called at a falling edge) until accepted or maxc cycles.
  task automatic send(input int unsigned k, input int unsigned m, input int unsigned maxc, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'(k);
    in_mode  = 2'(m);
    for (int unsigned c = 0; c < maxc && !ok; c++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(model(k, m));
        n_vec++;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_mode  = 2'($urandom);
  endtask

  task automatic drain(input int unsigned maxc);
    for (int unsigned c = 0; c < maxc && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_left", 257'(exp_q.size()), 257'(0));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ok;
    beat_t b;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 257'(out_valid), 257'(0));
    chk("rst_out_data",  257'(out_data),  257'(0));
    chk("rst_out_err",   257'(out_err),   257'(0));
    chk("rst_txn_count", 257'(txn_count), 257'(0));
    chk("rst_s_outs", {out_data_s, out_valid_s | out_err_s}, 257'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 257'(in_ready), 257'(1));
    chk("rel_in_ready_s", 257'(in_ready_s), 257'(1));

    // Single one-hot beat; stage B is still empty right after acceptance.
    send(5, 0, 5, ok);
    chk("acc_5", 257'(ok), 257'(1));
    idle();
    #1;
    chk("lat_not_early", 257'(out_valid), 257'(0));
    drain(10);

    // Back-to-back thermometer / inverted beats, then a reserved-mode beat.
    send(255, 1, 5, ok); chk("acc_t255", 257'(ok), 257'(1));
    send(0, 1, 5, ok);   chk("acc_t0", 257'(ok), 257'(1));
    send(3, 2, 5, ok);   chk("acc_i3", 257'(ok), 257'(1));
    send(7, 3, 5, ok);   chk("acc_r7", 257'(ok), 257'(1));
    idle();
    drain(10);

    // Stalled consumer: two beats fill the pipe, the third is refused.
    bp_mode = 1;
    @(negedge clk);
    send(1, 0, 5, ok); chk("acc_bp1", 257'(ok), 257'(1));
    send(2, 0, 5, ok); chk("acc_bp2", 257'(ok), 257'(1));
    send(3, 0, 6, ok); chk("refuse_bp3", 257'(ok), 257'(0));
    #1;
    chk("full_in_ready", 257'(in_ready), 257'(0));
    b = model(1, 0);
    chk("stall_data", 257'(out_data), 257'(b.d));
    bp_mode = 0;
    send(3, 0, 6, ok); chk("acc_bp3", 257'(ok), 257'(1));
    idle();
    drain(10);

    // Random traffic with random backpressure and input gaps.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) bp_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
      send($urandom_range(0, 255), $urandom_range(0, 3), 20, ok);
      chk("acc_rand", 257'(ok), 257'(1));
    end
    idle();
    bp_mode = 0;
    drain(50);

    // Reset with two beats in flight.
    bp_mode = 1;
    @(negedge clk);
    send(10, 1, 5, ok); chk("acc_f1", 257'(ok), 257'(1));
    send(11, 2, 5, ok); chk("acc_f2", 257'(ok), 257'(1));
    idle();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 257'(out_valid), 257'(0));
    chk("mid_rst_data",  257'(out_data),  257'(0));
    chk("mid_rst_count", 257'(txn_count), 257'(0));
    chk("mid_rst_count_s", 257'(txn_count_s), 257'(0));
    exp_q.delete();
    exp_cnt = 0;
    bp_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 257'(in_ready), 257'(1));
    send(9, 0, 5, ok); chk("acc_9", 257'(ok), 257'(1));
    idle();
    drain(10);

    // Enough handshakes for the narrow counter to saturate and stay there.
    for (int i = 0; i < 20; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 3), 5, ok);
      chk("acc_sat", 257'(ok), 257'(1));
    end
    idle();
    drain(10);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
